// File: rtl/frame_assembler.sv
// Collects four byte writes (slots 0..3, in order) into a 32-bit frame and holds it until accepted.
// Optional FRAME_PARITY_EN adds parity_o with per-byte even parity of frame_o.
module frame_assembler (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  add_i,
    input  logic [7:0]  data_i,
    input  logic        OE,
    input  logic        frame_ready_i,
    input  logic        err_clr_i,
    output logic [31:0] frame_o,
    output logic        frame_valid_o,
    output logic        busy_o,
    output logic        seq_err_o
`ifdef FRAME_PARITY_EN
    ,
    output logic [3:0]  parity_o
`endif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  exp_q, exp_d;
    logic [7:0]  slot_q [3];
    logic [7:0]  slot_d [3];
    logic [31:0] frame_q, frame_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        err_event;
    logic        wr, bad_addr, transfer;

    assign wr       = OE && (add_i <= 3'd3);
    assign bad_addr = OE && (add_i >= 3'd5);
    assign transfer = valid_q && frame_ready_i;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        slot_d    = slot_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        err_event = 1'b0;

        unique case (state_q)
            StFill: begin
                if (wr && (add_i[1:0] == exp_q)) begin
                    if (exp_q == 2'd3) begin
                        frame_d = {data_i, slot_q[2], slot_q[1], slot_q[0]};
                        valid_d = 1'b1;
                        exp_d   = 2'd0;
                        state_d = StHold;
                    end else begin
                        slot_d[exp_q] = data_i;
                        exp_d         = exp_q + 2'd1;
                    end
                end else if (wr || bad_addr) begin
                    err_event = 1'b1;
                    exp_d     = 2'd0;
                    state_d   = StIdle;
                end
            end
            StHold: begin
                if (!transfer) begin
                    // Overrun: pending frame is kept, incoming byte is lost
                    err_event = wr || bad_addr;
                end else begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                    if (wr && (add_i == 3'd0)) begin
                        slot_d[0] = data_i;
                        exp_d     = 2'd1;
                        state_d   = StFill;
                    end else if (wr || bad_addr) begin
                        err_event = 1'b1;
                    end
                end
            end
            default: begin
                if (wr && (add_i == 3'd0)) begin
                    slot_d[0] = data_i;
                    exp_d     = 2'd1;
                    state_d   = StFill;
                end else if (wr || bad_addr) begin
                    err_event = 1'b1;
                    exp_d     = 2'd0;
                end
            end
        endcase

        err_d = err_event ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            exp_q   <= 2'd0;
            slot_q  <= '{default: 8'h00};
            frame_q <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            slot_q  <= slot_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign frame_o       = frame_q;
    assign frame_valid_o = valid_q;
    assign busy_o        = (state_q != StIdle);
    assign seq_err_o     = err_q;

`ifdef FRAME_PARITY_EN
    logic [3:0] parity_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            parity_q <= 4'h0;
        end else begin
            parity_q <= {^frame_d[31:24], ^frame_d[23:16], ^frame_d[15:8], ^frame_d[7:0]};
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: tb/tb_frame_assembler.sv
// Directed self-checking bench for frame_assembler; covers parity_o when FRAME_PARITY_EN is set.
module tb_frame_assembler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  add_i = 3'd0;
    logic [7:0]  data_i = 8'h00;
    logic        OE = 1'b0;
    logic        frame_ready_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic [31:0] frame_o;
    logic        frame_valid_o;
    logic        busy_o;
    logic        seq_err_o;
`ifdef FRAME_PARITY_EN
    logic [3:0]  parity_o;
`endif

    int checks = 0;
    int errors = 0;

    frame_assembler dut (
        .CLK           (CLK),
        .RST           (RST),
        .add_i         (add_i),
        .data_i        (data_i),
        .OE            (OE),
        .frame_ready_i (frame_ready_i),
        .err_clr_i     (err_clr_i),
        .frame_o       (frame_o),
        .frame_valid_o (frame_valid_o),
        .busy_o        (busy_o),
        .seq_err_o     (seq_err_o)
`ifdef FRAME_PARITY_EN
        ,
        .parity_o      (parity_o)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic oe, input logic [2:0] a, input logic [7:0] d,
                        input logic rdy, input logic clr);
        OE            = oe;
        add_i         = a;
        data_i        = d;
        frame_ready_i = rdy;
        err_clr_i     = clr;
        @(posedge CLK);
        #1;
        OE            = 1'b0;
        frame_ready_i = 1'b0;
        err_clr_i     = 1'b0;
    endtask

    initial begin
        // Reset
        RST = 1'b1;
        step(1'b1, 3'd0, 8'hFF, 1'b1, 1'b0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        RST = 1'b0;
        chk("rst_frame", frame_o, 32'h0);
        chk("rst_valid", {31'b0, frame_valid_o}, 32'd0);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_err", {31'b0, seq_err_o}, 32'd0);

        // Basic frame
        step(1'b1, 3'd0, 8'h11, 1'b0, 1'b0);
        chk("fill_busy", {31'b0, busy_o}, 32'd1);
        chk("fill_valid", {31'b0, frame_valid_o}, 32'd0);
        step(1'b1, 3'd1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'h33, 1'b0, 1'b0);
        chk("pre3_valid", {31'b0, frame_valid_o}, 32'd0);
        step(1'b1, 3'd3, 8'h44, 1'b0, 1'b0);
        chk("f1_frame", frame_o, 32'h44332211);
        chk("f1_valid", {31'b0, frame_valid_o}, 32'd1);
        chk("f1_busy", {31'b0, busy_o}, 32'd1);
        step(1'b1, 3'd4, 8'h99, 1'b0, 1'b0);
        chk("wrap_noerr", {31'b0, seq_err_o}, 32'd0);
        chk("wrap_frame", frame_o, 32'h44332211);

        // Backpressure then transfer
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            chk("hold_frame", frame_o, 32'h44332211);
            chk("hold_valid", {31'b0, frame_valid_o}, 32'd1);
        end
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        chk("xfer_valid", {31'b0, frame_valid_o}, 32'd0);
        chk("xfer_busy", {31'b0, busy_o}, 32'd0);
        chk("xfer_frame", frame_o, 32'h44332211);

        // Sequence error and recovery
        step(1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 3'd3, 8'h03, 1'b0, 1'b0);
        chk("seq_err", {31'b0, seq_err_o}, 32'd1);
        chk("seq_idle", {31'b0, busy_o}, 32'd0);
        step(1'b1, 3'd0, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 3'd3, 8'hA3, 1'b0, 1'b0);
        chk("f2_frame", frame_o, 32'hA3A2A1A0);
        chk("f2_valid", {31'b0, frame_valid_o}, 32'd1);
        chk("f2_err_sticky", {31'b0, seq_err_o}, 32'd1);
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        chk("clr_err", {31'b0, seq_err_o}, 32'd0);
        chk("f2_xfer", {31'b0, frame_valid_o}, 32'd0);
        // Set wins over clear
        step(1'b1, 3'd2, 8'h00, 1'b0, 1'b1);
        chk("set_wins", {31'b0, seq_err_o}, 32'd1);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        chk("clr_again", {31'b0, seq_err_o}, 32'd0);

        // Overrun in HOLD, then write on transfer cycle
        step(1'b1, 3'd0, 8'hB0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'hB2, 1'b0, 1'b0);
        step(1'b1, 3'd3, 8'hB3, 1'b0, 1'b0);
        step(1'b1, 3'd0, 8'h77, 1'b0, 1'b0);
        chk("ovr_err", {31'b0, seq_err_o}, 32'd1);
        chk("ovr_frame", frame_o, 32'hB3B2B1B0);
        chk("ovr_valid", {31'b0, frame_valid_o}, 32'd1);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 3'd0, 8'h55, 1'b1, 1'b0);
        chk("xw_valid", {31'b0, frame_valid_o}, 32'd0);
        chk("xw_busy", {31'b0, busy_o}, 32'd1);
        chk("xw_err", {31'b0, seq_err_o}, 32'd0);
        step(1'b1, 3'd1, 8'h66, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'h77, 1'b0, 1'b0);
        step(1'b1, 3'd3, 8'h88, 1'b0, 1'b0);
        chk("f3_frame", frame_o, 32'h88776655);
        step(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);

        // Illegal address mid-fill
        step(1'b1, 3'd0, 8'h10, 1'b0, 1'b0);
        step(1'b1, 3'd6, 8'h11, 1'b0, 1'b0);
        chk("bad_addr_err", {31'b0, seq_err_o}, 32'd1);
        chk("bad_addr_idle", {31'b0, busy_o}, 32'd0);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

        // Reset mid-fill
        step(1'b1, 3'd0, 8'h12, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'h34, 1'b0, 1'b0);
        RST = 1'b1;
        step(1'b1, 3'd2, 8'h56, 1'b0, 1'b0);
        RST = 1'b0;
        chk("mrst_frame", frame_o, 32'h0);
        chk("mrst_valid", {31'b0, frame_valid_o}, 32'd0);
        chk("mrst_busy", {31'b0, busy_o}, 32'd0);
        chk("mrst_err", {31'b0, seq_err_o}, 32'd0);
        step(1'b1, 3'd2, 8'h56, 1'b0, 1'b0);
        chk("mrst_no_resume", {31'b0, seq_err_o}, 32'd1);
        step(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

`ifdef FRAME_PARITY_EN
        chk("rst_parity", {28'b0, parity_o}, 32'd0);
        step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 3'd1, 8'h07, 1'b0, 1'b0);
        step(1'b1, 3'd2, 8'h03, 1'b0, 1'b0);
        step(1'b1, 3'd3, 8'h01, 1'b0, 1'b0);
        chk("par_frame", frame_o, 32'h01030700);
        chk("par_bits", {28'b0, parity_o}, 32'h0000000A);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_assembler.md
FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port add_i, input, 3 bits: slot address from the address stage (valid sequence 0,1,2,3, then wrap value 4).
REQ-004 SHALL have port data_i, input, 8 bits: byte to store at add_i.
REQ-005 SHALL have port OE, input, 1 bit: write strobe; add_i and data_i are sampled when OE=1.
REQ-006 SHALL have port frame_ready_i, input, 1 bit: downstream accepts the frame.
REQ-007 SHALL have port err_clr_i, input, 1 bit: clears seq_err_o.
REQ-008 SHALL have port frame_o, output, 32 bits: assembled frame {slot3,slot2,slot1,slot0}.
REQ-009 SHALL have port frame_valid_o, output, 1 bit: frame_o holds a complete frame.
REQ-010 SHALL have port busy_o, output, 1 bit: high in FILL and HOLD.
REQ-011 SHALL have port seq_err_o, output, 1 bit: sticky sequence/overrun error.

Function
REQ-012 SHALL implement three states: IDLE, FILL and HOLD, plus a 2-bit expected-slot counter exp.
REQ-013 SHALL treat a cycle as a write when OE=1 and add_i<=3; OE=1 with add_i==4 SHALL be ignored with no error.
REQ-014 SHALL, in IDLE, on a write with add_i==0, store data_i in slot0, set exp=1 and go to FILL.
REQ-015 SHALL, in FILL, on a write with add_i==exp, store data_i in slot[exp] and increment exp.
REQ-016 SHALL, on the write to slot3, on the same clock edge load frame_o with {data_i,slot2,slot1,slot0}, set frame_valid_o=1, reset exp=0 and go to HOLD; frame_valid_o is therefore high the cycle after the slot3 write (one-cycle latency).
REQ-017 SHALL, in IDLE or FILL, on a write with add_i!=exp, or on OE=1 with add_i in 5..7, set seq_err_o, discard the partial frame, reset exp=0 and go to IDLE.
REQ-018 SHALL hold frame_o and frame_valid_o stable in HOLD until frame_valid_o and frame_ready_i are both 1 (transfer).
REQ-019 SHALL, on the transfer cycle, clear frame_valid_o on the next edge and go to IDLE; if that cycle also carries a write with add_i==0, it SHALL be accepted as in REQ-014 (go to FILL instead).
REQ-020 SHALL, in HOLD on a non-transfer cycle, drop any write and set seq_err_o (overrun); frame_o SHALL stay unchanged.
REQ-021 SHALL clear seq_err_o when err_clr_i=1 unless an error event occurs in the same cycle, in which case set wins.
REQ-022 SHALL keep frame_o unchanged outside the load in REQ-016.

Reset
REQ-023 SHALL, when RST=1 at a clock edge, force state IDLE, exp=0, slots=0, frame_o=0, frame_valid_o=0, busy_o=0, seq_err_o=0, overriding all other inputs.
REQ-024 SHALL, when reset is applied mid-FILL or in HOLD, discard the partial or pending frame with no transfer.

Configuration
REQ-025 SHALL, with macro FRAME_PARITY_EN defined, add output parity_o (4 bits), where bit k is the even parity (XOR) of byte k of frame_o, registered with frame_o and reset to 0.
REQ-026 SHALL, with FRAME_PARITY_EN undefined, omit the parity_o port and its logic; all other behaviour SHALL be identical.

Verification
REQ-027 Writes 0:11, 1:22, 2:33, 3:44, then 4 -> frame_o=0x44332211 and frame_valid_o=1 the cycle after the slot3 write; busy_o=1 from the slot0 write until transfer.
REQ-028 Frame pending with frame_ready_i=0 for 5 cycles, then 1 -> frame_o stable for all cycles, frame_valid_o drops after the transfer edge.
REQ-029 Writes 0, 1, then 3 -> seq_err_o=1, state IDLE; a fresh 0..3 sequence (0xA0..0xA3) yields 0xA3A2A1A0; err_clr_i=1 then clears seq_err_o.
REQ-030 Write during HOLD without ready -> seq_err_o=1, frame_o unchanged; write 0:55 on the transfer cycle -> accepted, state FILL.
REQ-031 RST=1 after slot1 write -> all outputs 0 next cycle; with FRAME_PARITY_EN, frame 0x01030700 -> parity_o=4'b1010.
